// File: rtl/as_gpio_ctrl_pkg.sv
// Package for the GPIO peripheral: pad count, address width and register indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package as_pack;

    localparam int nr_gpios        = 8;
    localparam int gpio_addr_width = 4;

    // Word index of each architected register; anything else is unmapped.
    typedef enum logic [gpio_addr_width-1:0] {
        GPIO_DOUT  = 4'd0,
        GPIO_DIR   = 4'd1,
        GPIO_DIN   = 4'd2,
        GPIO_IEN   = 4'd3,
        GPIO_ISTAT = 4'd4
    } gpio_reg_e;

endpackage

// File: rtl/as_gpio_ctrl_if.sv
// Data-bus port between the load/store unit (master) and the GPIO block (slave).
// Latency: one access per cycle, ack/rdata registered one cycle later.
// Backpressure: none; the slave never inserts wait states.
interface as_gpio_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 64
) ();
    logic              sel_i;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic [DATA_W-1:0] rdata_o;
    logic              ack_o;

    modport master (output sel_i, output we_i, output addr_i, output wdata_i,
                    input  rdata_o, input  ack_o);
    modport slave  (input  sel_i, input  we_i, input  addr_i, input  wdata_i,
                    output rdata_o, output ack_o);
endinterface

// File: rtl/as_gpio_sync.sv
// Two-flop synchroniser for asynchronous pad inputs, reset to 0.
// Latency: 2 clock edges from d_i to q_o.
// Backpressure: none.
module as_gpio_sync #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] r_meta;
    logic [W-1:0] r_q;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_meta <= '0;
            r_q    <= '0;
        end else begin
            r_meta <= d_i;
            r_q    <= r_meta;
        end
    end

    assign q_o = r_q;
endmodule

// File: rtl/as_gpio_ctrl.sv
// Memory-mapped GPIO: DOUT/DIR/DIN registers, tri-state pads, cs_o strobe per DOUT write;
// optional rising-edge interrupt unit when AS_GPIO_IRQ_EN is defined.
// Latency: ack/rdata/cs_o one cycle after access; no wait states, no backpressure.
module as_gpio_ctrl
    import as_pack::*;
#(
    parameter int NR_GPIOS = nr_gpios,
    parameter int ADDR_W   = gpio_addr_width,
    parameter int DATA_W   = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    as_gpio_ctrl_if.slave       bus,
    inout  wire  [NR_GPIOS-1:0] gpio_io,
    output logic                cs_o,
    output logic                irq_o
);
    localparam logic [ADDR_W-1:0] A_DOUT  = ADDR_W'(GPIO_DOUT);
    localparam logic [ADDR_W-1:0] A_DIR   = ADDR_W'(GPIO_DIR);
    localparam logic [ADDR_W-1:0] A_DIN   = ADDR_W'(GPIO_DIN);
`ifdef AS_GPIO_IRQ_EN
    localparam logic [ADDR_W-1:0] A_IEN   = ADDR_W'(GPIO_IEN);
    localparam logic [ADDR_W-1:0] A_ISTAT = ADDR_W'(GPIO_ISTAT);
`endif

    logic [NR_GPIOS-1:0] r_dout;
    logic [NR_GPIOS-1:0] r_dir;
    logic                r_ack;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_cs;
    logic [NR_GPIOS-1:0] w_din;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_wr;
    logic [NR_GPIOS-1:0] w_wdat;
    logic                w_unused;

    assign w_wr     = bus.sel_i & bus.we_i;
    assign w_wdat   = bus.wdata_i[NR_GPIOS-1:0];
    assign w_unused = ^bus.wdata_i[DATA_W-1:NR_GPIOS];

    // Each pad drives its DOUT bit only while configured as an output.
    for (genvar g = 0; g < NR_GPIOS; g++) begin : g_pad
        assign gpio_io[g] = r_dir[g] ? r_dout[g] : 1'bz;
    end

    // Output-driven pads loop back through the synchroniser, so DIN reads the driven value.
    as_gpio_sync #(.W(NR_GPIOS)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (gpio_io),
        .q_o   (w_din)
    );

`ifdef AS_GPIO_IRQ_EN
    logic [NR_GPIOS-1:0] r_ien;
    logic [NR_GPIOS-1:0] r_istat;
    logic [NR_GPIOS-1:0] r_din_d;
    logic                r_irq;
    logic [NR_GPIOS-1:0] w_rise;
    logic [NR_GPIOS-1:0] w_clr;

    assign w_rise = w_din & ~r_din_d & r_ien;
    assign w_clr  = (w_wr && bus.addr_i == A_ISTAT) ? w_wdat : '0;

    // Edge detector and sticky status; a new edge beats a same-cycle W1C clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ien   <= '0;
            r_istat <= '0;
            r_din_d <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_din_d <= w_din;
            r_istat <= (r_istat & ~w_clr) | w_rise;
            r_irq   <= |r_istat;
            if (w_wr && bus.addr_i == A_IEN) r_ien <= w_wdat;
        end
    end

    assign irq_o = r_irq;
`else
    assign irq_o = 1'b0;
`endif

    // Read mux: registered values as they stand before this edge, zero-extended.
    always_comb begin
        w_rdata = '0;
        case (bus.addr_i)
            A_DOUT:  w_rdata[NR_GPIOS-1:0] = r_dout;
            A_DIR:   w_rdata[NR_GPIOS-1:0] = r_dir;
            A_DIN:   w_rdata[NR_GPIOS-1:0] = w_din;
`ifdef AS_GPIO_IRQ_EN
            A_IEN:   w_rdata[NR_GPIOS-1:0] = r_ien;
            A_ISTAT: w_rdata[NR_GPIOS-1:0] = r_istat;
`endif
            default: w_rdata = '0;
        endcase
    end

    // Register writes, single-cycle ack/rdata, and the DOUT-write strobe.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_dout  <= '0;
            r_dir   <= '0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_cs    <= 1'b0;
        end else begin
            r_ack   <= bus.sel_i;
            r_rdata <= (bus.sel_i && !bus.we_i) ? w_rdata : '0;
            r_cs    <= w_wr && (bus.addr_i == A_DOUT);
            if (w_wr && bus.addr_i == A_DOUT) r_dout <= w_wdat;
            if (w_wr && bus.addr_i == A_DIR)  r_dir  <= w_wdat;
        end
    end

    assign bus.ack_o   = r_ack;
    assign bus.rdata_o = r_rdata;
    assign cs_o        = r_cs;
endmodule

// File: tb/tb_as_gpio_ctrl.sv
// Self-checking bench for as_gpio_ctrl: directed scenarios plus random bus/pad traffic
// checked every cycle against a register-level reference model.
// Build with or without AS_GPIO_IRQ_EN; the interrupt checks follow the build.
module tb_as_gpio_ctrl;
    localparam int N  = 8;
    localparam int AW = 4;
    localparam int DW = 64;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic cs_o, irq_o;
    wire  [N-1:0] gpio_io;
    logic [N-1:0] tb_do = '0;

    as_gpio_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    // Reference model state (values holding after the latest clock edge).
    logic [N-1:0]  m_dout, m_dir, m_ien, m_istat;
    logic [N-1:0]  s0, s1, s2;   // pad samples taken 1, 2 and 3 edges ago
    logic [DW-1:0] m_rdata;
    logic          m_ack, m_cs, m_irq;

    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   chk_on = 1'b0;
    logic [N-1:0] cs_log[$];

    // The bench drives every pad the DUT is not supposed to drive.
    for (genvar i = 0; i < N; i++) begin : g_tbpad
        assign gpio_io[i] = m_dir[i] ? 1'bz : tb_do[i];
    end

    as_gpio_ctrl #(.NR_GPIOS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .bus     (bus),
        .gpio_io (gpio_io),
        .cs_o    (cs_o),
        .irq_o   (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: register file semantics as seen from the bus and pads.
    always @(posedge clk_i or negedge rst_i) begin : mdl
        logic [N-1:0] pad, rise, wv, clr;
        logic         wr;
        if (!rst_i) begin
            m_dout = '0; m_dir = '0; m_ien = '0; m_istat = '0;
            s0 = '0; s1 = '0; s2 = '0;
            m_rdata = '0; m_ack = 1'b0; m_cs = 1'b0; m_irq = 1'b0;
        end else begin
            pad = (m_dout & m_dir) | (tb_do & ~m_dir);
            wv  = bus.wdata_i[N-1:0];
            wr  = bus.sel_i && bus.we_i;
            // DIN currently visible is the pad two samples back; an edge is 0 then 1.
`ifdef AS_GPIO_IRQ_EN
            rise  = s1 & ~s2 & m_ien;
            m_irq = (m_istat != 0);
`else
            rise  = '0;
            m_irq = 1'b0;
`endif
            m_ack   = bus.sel_i;
            m_cs    = wr && bus.addr_i == 0;
            m_rdata = '0;
            if (bus.sel_i && !bus.we_i) begin
                case (int'(bus.addr_i))
                    0: m_rdata = DW'(m_dout);
                    1: m_rdata = DW'(m_dir);
                    2: m_rdata = DW'(s1);
`ifdef AS_GPIO_IRQ_EN
                    3: m_rdata = DW'(m_ien);
                    4: m_rdata = DW'(m_istat);
`endif
                    default: m_rdata = '0;
                endcase
            end
            clr = '0;
`ifdef AS_GPIO_IRQ_EN
            if (wr && bus.addr_i == 4) clr = wv;
            if (wr && bus.addr_i == 3) m_ien = wv;
`endif
            m_istat = (m_istat & ~clr) | rise;
            if (wr && bus.addr_i == 0) m_dout = wv;
            if (wr && bus.addr_i == 1) m_dir  = wv;
            s2 = s1; s1 = s0; s0 = pad;
        end
    end

    // Per-cycle compare of every DUT output against the model, away from the active edge.
    always @(negedge clk_i) begin
        if (chk_on) begin
            chk("ack", 64'(bus.ack_o), 64'(m_ack));
            if (m_ack) chk("rdata", bus.rdata_o, m_rdata);
            chk("cs", 64'(cs_o), 64'(m_cs));
            chk("irq", 64'(irq_o), 64'(m_irq));
            chk("pad_out", 64'(gpio_io & m_dir), 64'(m_dout & m_dir));
            chk("pad_in", 64'(gpio_io & ~m_dir), 64'(tb_do & ~m_dir));
            if (cs_o) cs_log.push_back(gpio_io);
        end
    end

    task automatic acc(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk_i); #1;
        bus.sel_i = 1'b1; bus.we_i = we; bus.addr_i = a; bus.wdata_i = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i); #1;
            bus.sel_i = 1'b0;
        end
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] data, output logic ackv);
        acc(1'b0, a, '0);
        @(negedge clk_i);
        data = bus.rdata_o; ackv = bus.ack_o;
        #1 bus.sel_i = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          k;
        bus.sel_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;

        // Reset state.
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ack", 64'(bus.ack_o), 64'd0);
        chk("rst_cs", 64'(cs_o), 64'd0);
        chk("rst_irq", 64'(irq_o), 64'd0);
        chk("rst_rdata", bus.rdata_o, 64'd0);
        chk("rst_pads_z", 64'(gpio_io), 64'(tb_do));
        #1 rst_i = 1'b1;
        chk_on = 1'b1;

        // Output sequence: four strobes, each with its own pad value.
        acc(1'b1, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        cs_log.delete();
        acc(1'b1, 4'd0, 64'd1);
        acc(1'b1, 4'd0, 64'd3);
        acc(1'b1, 4'd0, 64'd5);
        acc(1'b1, 4'd0, 64'd7);
        idle(2);
        chk("seq_cnt", 64'(cs_log.size()), 64'd4);
        if (cs_log.size() == 4) begin
            chk("seq_v0", 64'(cs_log[0]), 64'd1);
            chk("seq_v1", 64'(cs_log[1]), 64'd3);
            chk("seq_v2", 64'(cs_log[2]), 64'd5);
            chk("seq_v3", 64'(cs_log[3]), 64'd7);
        end

        // Input path.
        acc(1'b1, 4'd1, 64'd0);
        tb_do = 8'hA5;
        idle(3);
        chk("in_pads", 64'(gpio_io), 64'hA5);
        rd(4'd2, d, k);
        chk("in_din", d, 64'h0000_0000_0000_00A5);
        chk("in_ack", 64'(k), 64'd1);

        // Mixed direction.
        acc(1'b1, 4'd1, 64'h0F);
        acc(1'b1, 4'd0, 64'hFF);
        tb_do = 8'h30;
        idle(3);
        chk("mix_pads", 64'(gpio_io), 64'h3F);
        rd(4'd2, d, k);
        chk("mix_din", d, 64'h3F);

        // Interrupt path (or its absence).
        acc(1'b1, 4'd1, 64'd0);
        tb_do = 8'h00;
        idle(4);
`ifdef AS_GPIO_IRQ_EN
        acc(1'b1, 4'd4, 64'hFF);
        acc(1'b1, 4'd3, 64'h01);
        idle(1);
        tb_do = 8'h01;
        repeat (3) @(negedge clk_i);
        chk("irq_e3", 64'(irq_o), 64'd0);
        @(negedge clk_i);
        chk("irq_e4", 64'(irq_o), 64'd1);
        rd(4'd4, d, k);
        chk("istat_rd", d, 64'd1);
        acc(1'b1, 4'd4, 64'h01);
        @(negedge clk_i);
        chk("irq_hold", 64'(irq_o), 64'd1);
        #1 bus.sel_i = 1'b0;
        @(negedge clk_i);
        chk("irq_clr", 64'(irq_o), 64'd0);
`else
        acc(1'b1, 4'd3, 64'hFF);
        idle(1);
        tb_do = 8'hFF;
        idle(6);
        chk("noirq", 64'(irq_o), 64'd0);
        rd(4'd3, d, k);
        chk("noirq_ien", d, 64'd0);
        rd(4'd4, d, k);
        chk("noirq_istat", d, 64'd0);
`endif

        // Unmapped index: acked, no strobe, no register change.
        cs_log.delete();
        acc(1'b1, 4'd7, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk_i);
        chk("unm_ack", 64'(bus.ack_o), 64'd1);
        #1 bus.sel_i = 1'b0;
        rd(4'd7, d, k);
        chk("unm_rd", d, 64'd0);
        rd(4'd0, d, k);
        chk("unm_dout", d, 64'hFF);
        chk("unm_nocs", 64'(cs_log.size()), 64'd0);

        // Random bus and pad traffic.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk_i); #1;
            bus.sel_i   = ($urandom_range(0, 3) != 0);
            bus.we_i    = $urandom_range(0, 1);
            bus.addr_i  = ($urandom_range(0, 15) == 0) ? 4'(15) : 4'($urandom_range(0, 7));
            bus.wdata_i = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) tb_do = N'($urandom);
        end
        idle(2);

        // Reset asserted mid-access: the DOUT write is dropped, no ack follows.
        acc(1'b1, 4'd0, 64'h5A);
        #2 rst_i = 1'b0;
        @(negedge clk_i);
        chk("mrst_ack", 64'(bus.ack_o), 64'd0);
        chk("mrst_cs", 64'(cs_o), 64'd0);
        chk("mrst_irq", 64'(irq_o), 64'd0);
        chk("mrst_rdata", bus.rdata_o, 64'd0);
        chk("mrst_pads", 64'(gpio_io), 64'(tb_do));
        #1 bus.sel_i = 1'b0;
        @(negedge clk_i); #1 rst_i = 1'b1;
        rd(4'd0, d, k);
        chk("mrst_dout", d, 64'd0);
        idle(3);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/as_gpio_ctrl.md
# as_gpio_ctrl

Memory-mapped GPIO peripheral on the core's data bus, between the RV64I load/store unit and the `gpio_io` pads of `as_top_mem`. It holds the output and direction registers, synchronises pad inputs, and issues a one-cycle `cs_o` strobe on every write to the output register. Integration benches sample `gpio_io` on that strobe. An optional interrupt unit flags rising edges on input pins.

## Interface
Reset is asynchronous and active-low. It is named as the codebase does.

Parameters:
- `NR_GPIOS`, default `nr_gpios` (8): number of pads.
- `ADDR_W`, default `gpio_addr_width` (4): word-address width.
- `DATA_W`, default 64: bus data width.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: asynchronous, active-low reset.
- `sel_i` in 1: bus access valid this cycle.
- `we_i` in 1: 1 = write, 0 = read.
- `addr_i` in `ADDR_W`: register word index.
- `wdata_i` in `DATA_W`: write data.
- `rdata_o` out `DATA_W`: read data, valid with `ack_o`.
- `ack_o` out 1: access complete.
- `gpio_io` inout `NR_GPIOS`: pads, tri-state per bit.
- `cs_o` out 1: output-update strobe.
- `irq_o` out 1: level interrupt.

## Operation
Register map (word index):
- 0 `DOUT` (RW)
- 1 `DIR` (RW; 1 = output)
- 2 `DIN` (RO)
- 3 `IEN` (RW)
- 4 `ISTAT` (RW1C)
- Any other index reads 0. Writes to other indices are ignored but still acked.

Data and pad behaviour:
- Writes take `wdata_i[NR_GPIOS-1:0]`; upper bits are ignored. Reads are zero-extended to `DATA_W`.
- Pad bit `i` drives `DOUT[i]` when `DIR[i]=1`, else `'z`.
- `DIN` is the 2-flop synchronised pad value. Output-driven bits read back their driven value.

Strobe:
- A write to `DOUT` (index 0) sets `cs_o` for exactly one cycle, registered.
- The strobe fires even if the written value equals the old value.

Interrupt (`AS_GPIO_IRQ_EN`):
- `ISTAT[i]` sets on a synced 0→1 transition of `DIN[i]` when `IEN[i]=1`.
- Writing 1 to a bit of `ISTAT` clears it.
- Set wins over a same-cycle clear.
- `irq_o = |ISTAT`, registered.

## Timing
- **Reset:** `DOUT=0`, `DIR=0` (all pads `z`), `IEN=0`, `ISTAT=0`, synchroniser flops 0, `rdata_o=0`, `ack_o=0`, `cs_o=0`, `irq_o=0`. Reset asserted mid-access drops the access; no `ack_o` follows.
- **Access:** accepted on any rising edge with `sel_i=1`. `ack_o` and `rdata_o` are registered and valid on the next cycle. Back-to-back accesses are allowed, one per cycle, acked one per cycle in order. No wait states.
- **DOUT write** accepted at edge N:
  - register and pads update at edge N;
  - `cs_o` is high from edge N to N+1, so pads are stable for the whole strobe;
  - consecutive `DOUT` writes give consecutive one-cycle strobes, each with its own value.
- **Input latency:** a pad change reaches `DIN` 2 edges later. A read accepted on the following edge returns it.
- **Read/write to the same register in consecutive cycles:** the read returns the newly written value.
- **Interrupt:** `irq_o` rises 1 cycle after `ISTAT` sets, i.e. 4 edges after the pad edge.

## Configuration
`AS_GPIO_IRQ_EN`:
- **Defined:** the `IEN`/`ISTAT` registers, edge detector and `irq_o` logic are compiled in.
- **Undefined:** indices 3 and 4 behave as unmapped (read 0, writes ignored) and `irq_o` is tied to 0. `DOUT`, `DIR`, `DIN` and `cs_o` timing are identical in both builds.

## Structure
- `as_pack` holds:
  - `nr_gpios` and `gpio_addr_width`;
  - a `gpio_reg_e` enum of register indices (`GPIO_DOUT=0` … `GPIO_ISTAT=4`).
- One sub-module, `as_gpio_sync`: parameterised-width 2-flop synchroniser with asynchronous active-low reset to 0.

## Test plan
1. **Output sequence:** write `DIR=0xFF`, then `DOUT`=1, 3, 5, 7 on consecutive cycles → four one-cycle `cs_o` pulses with `gpio_io`=1, 3, 5, 7 respectively, sampled at the negedge.
2. **Input path:** `DIR=0x00`, bench drives `gpio_io=0xA5` → pads undriven by the DUT. A `DIN` read issued ≥2 cycles later returns `0x00000000000000A5` with `ack_o` one cycle after `sel_i`.
3. **Mixed direction:** `DIR=0x0F`, `DOUT=0xFF`, bench drives the upper nibble to `0x3` → `gpio_io=0x3F`, and `DIN` reads `0x3F`.
4. **Interrupt** (macro defined): `IEN=0x01`, pad 0 rises → `irq_o=1` after 4 edges. Writing `ISTAT=0x01` clears it, and `irq_o=0` next cycle.
5. **Unmapped write and reset:**
   - write index 7 → `ack_o` high, no `cs_o`, no register change;
   - read index 7 → 0;
   - assert `rst_i` low mid-access → all outputs at reset values, no ack.
6. **Build without `AS_GPIO_IRQ_EN`:** `IEN`/`ISTAT` read 0, and `irq_o` stays 0 with pad edges applied.
